// File: rtl/spi_frame_writer.sv
// spi_frame_writer: samples SPI in the clk domain, assembles 16-bit pixel words and
// writes them to a double-buffered pixel RAM, flipping banks only on a complete frame.
module spi_frame_writer #(
  parameter int FRAME_WORDS = 2048,
  parameter int ADDR_BITS   = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_sclk,
  input  logic                 spi_mosi,
  input  logic                 spi_cs_n,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [15:0]          wr_data,
  output logic                 wr_bank,
  output logic                 disp_bank,
  output logic                 frame_done,
  output logic                 frame_err
);
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECEIVE, DISCARD} state_t;
  localparam logic [ADDR_BITS:0] LAST_WORD = (ADDR_BITS+1)'(FRAME_WORDS - 1);
  state_t              state;
  logic [2:0]          sclk_s, cs_s;
  logic [1:0]          mosi_s;
  logic                sclk_rise, cs_fall, cs_rise, mosi_bit;
  logic [3:0]          bit_cnt;
  logic [ADDR_BITS:0]  word_cnt;
  logic [15:0]         shift;
  logic                word_end, frame_end;
  assign word_end  = sclk_rise && bit_cnt == 4'd15;
  assign frame_end = word_end && word_cnt == LAST_WORD;
  assign disp_bank = ~wr_bank;
  // [0]=s1, [1]=s2, [2]=s3; edge strobes and the sampled bit are registered together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {sclk_s, cs_s, mosi_s} <= '0;
      {sclk_rise, cs_fall, cs_rise, mosi_bit} <= '0;
    end else begin
      sclk_s    <= {sclk_s[1:0], spi_sclk};
      cs_s      <= {cs_s[1:0], spi_cs_n};
      mosi_s    <= {mosi_s[0], spi_mosi};
      sclk_rise <= sclk_s[1] & ~sclk_s[2];
      cs_fall   <= ~cs_s[1] & cs_s[2];
      cs_rise   <= cs_s[1] & ~cs_s[2];
      mosi_bit  <= mosi_s[1];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_IDLE;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      shift      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_bank    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        WAIT_IDLE: if (cs_s[1]) state <= IDLE;
        IDLE: if (cs_fall) begin
          bit_cnt  <= '0;
          word_cnt <= '0;
          state    <= RECEIVE;
        end
        RECEIVE: begin
          if (sclk_rise) begin
            shift   <= {shift[14:0], mosi_bit};
            bit_cnt <= bit_cnt + 4'd1;
          end
          if (word_end) begin
            wr_en    <= 1'b1;
            wr_addr  <= word_cnt[ADDR_BITS-1:0];
            wr_data  <= {shift[14:0], mosi_bit};
            word_cnt <= word_cnt + 1'b1;
          end
          // a completing frame wins over a coincident CS release
          if (frame_end) begin
            frame_done <= 1'b1;
            wr_bank    <= ~wr_bank;
            state      <= cs_rise ? IDLE : DISCARD;
          end else if (cs_rise) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        DISCARD: if (cs_rise) state <= IDLE;
        default: state <= WAIT_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_frame_writer.sv
// tb_spi_frame_writer: random SPI stimulus checked cycle by cycle against a pin-level frame model.
module tb_spi_frame_writer;
  localparam int FW = 128;
  localparam int AB = 7;
  logic clk = 0, reset = 1, spi_sclk = 0, spi_mosi = 0, spi_cs_n = 0;
  logic wr_en, wr_bank, disp_bank, frame_done, frame_err;
  logic [AB-1:0] wr_addr;
  logic [15:0] wr_data;

  spi_frame_writer #(.FRAME_WORDS(FW), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bank(wr_bank),
    .disp_bank(disp_bank), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    bit            we;
    logic [AB-1:0] addr;
    logic [15:0]   data;
    bit            done;
    bit            err;
  } ev_t;
  ev_t q[$];
  ev_t e;
  int checks = 0, fails = 0;
  int n_wr = 0, n_done = 0, n_err = 0;
  logic [AB-1:0] addr_log[$];
  logic [15:0] data_log[$];
  logic [AB-1:0] done_addr;
  bit exp_bank = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Each expected event lands 4 cycles after the pin change that causes it
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_bank = 0;
    end
    if (wr_en) begin
      n_wr++;
      addr_log.push_back(wr_addr);
      data_log.push_back(wr_data);
    end
    if (frame_done) begin
      n_done++;
      done_addr = wr_addr;
    end
    if (frame_err) n_err++;
    if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("wr_en", wr_en, e.we);
      if (e.we) begin
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
      end
      chk("frame_done", frame_done, e.done);
      chk("frame_err", frame_err, e.err);
      if (e.done) exp_bank = !exp_bank;
    end else begin
      chk("wr_en_quiet", wr_en, 0);
      chk("frame_done_quiet", frame_done, 0);
      chk("frame_err_quiet", frame_err, 0);
    end
    chk("wr_bank", wr_bank, exp_bank);
    chk("disp_bank", disp_bank, !exp_bank);
  end

  bit armed = 0, in_frame = 0, done = 0;
  int bits = 0, words = 0;
  logic [15:0] sh = 0;

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(bit we, int a, logic [15:0] d, bit dn, bit er);
    ev_t x;
    x.due = cyc + 4; x.we = we; x.addr = AB'(a); x.data = d; x.done = dn; x.err = er;
    q.push_back(x);
  endtask

  task automatic rise_model(bit b);
    if (in_frame && !done) begin
      sh = {sh[14:0], b};
      bits++;
      if (bits == 16) begin
        bits = 0;
        push(1, words, sh, words == FW - 1, 0);
        words++;
        if (words == FW) done = 1;
      end
    end
  endtask

  task automatic cs_fall_model();
    if (armed) begin
      in_frame = 1; done = 0; bits = 0; words = 0;
    end
  endtask

  task automatic cs_rise_model();
    if (in_frame && !done) push(0, 0, 16'h0, 0, 1);
    in_frame = 0;
  endtask

  task automatic send_bit(bit b, bit rnd);
    int lo, hi;
    lo = rnd ? int'($urandom_range(3, 2)) : 2;
    hi = rnd ? int'($urandom_range(3, 2)) : 2;
    spi_sclk = 0; spi_mosi = b;
    tick(lo);
    spi_sclk = 1;
    rise_model(b);
    tick(hi);
  endtask

  task automatic send_word(logic [15:0] d, bit rnd);
    for (int i = 15; i >= 0; i--) send_bit(d[i], rnd);
  endtask

  task automatic start_frame();
    spi_cs_n = 0;
    cs_fall_model();
    tick(2);
  endtask

  task automatic end_frame();
    spi_sclk = 0;
    tick(2);
    spi_cs_n = 1;
    cs_rise_model();
    tick(6);
  endtask

  task automatic body(int nw, int nb, bit rnd, bit seq);
    logic [15:0] d;
    for (int w = 0; w < nw; w++) begin
      d = seq ? 16'(16'hF0A0 + w) : 16'($urandom);
      send_word(d, rnd);
    end
    for (int i = 0; i < nb; i++) send_bit(1'($urandom), rnd);
  endtask

  task automatic frame(int nw, int nb, bit rnd, bit seq);
    start_frame();
    body(nw, nb, rnd, seq);
    end_frame();
  endtask

  task automatic release_cs();
    spi_sclk = 0;
    tick(2);
    spi_cs_n = 1;
    tick(6);
    armed = 1;
  endtask

  int w0, d0, r0;

  initial begin
    tick(1);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_disp_bank", disp_bank, 1);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_err", frame_err, 0);
    reset = 0;
    for (int i = 0; i < 40; i++) send_bit(1'($urandom), 0);
    chk("no_write_before_cs_cycle", n_wr, 0);
    release_cs();

    w0 = n_wr; d0 = n_done; r0 = n_err;
    frame(FW, 0, 0, 1);
    chk("single_writes", n_wr - w0, FW);
    chk("single_done", n_done - d0, 1);
    chk("single_err", n_err - r0, 0);
    chk("single_first_addr", addr_log[w0], 0);
    chk("single_first_data", data_log[w0], 16'hF0A0);
    chk("single_last_addr", addr_log[w0+FW-1], 127);
    chk("single_last_data", data_log[w0+FW-1], 16'hF11F);
    chk("single_done_addr", done_addr, 127);
    chk("single_wr_bank", wr_bank, 1);
    chk("single_disp_bank", disp_bank, 0);

    w0 = n_wr; d0 = n_done; r0 = n_err;
    frame(100, 5, 1, 0);
    chk("abort_writes", n_wr - w0, 100);
    chk("abort_err", n_err - r0, 1);
    chk("abort_done", n_done - d0, 0);
    chk("abort_wr_bank", wr_bank, 1);

    w0 = n_wr; d0 = n_done;
    frame(FW, 0, 0, 0);
    chk("restart_addr", addr_log[w0], 0);
    chk("b2b_done", n_done - d0, 1);
    chk("b2b_wr_bank", wr_bank, 0);

    w0 = n_wr; d0 = n_done; r0 = n_err;
    frame(FW + 2, 0, 0, 0);
    chk("overlong_writes", n_wr - w0, FW);
    chk("overlong_done", n_done - d0, 1);
    chk("overlong_err", n_err - r0, 0);
    chk("overlong_wr_bank", wr_bank, 1);

    w0 = n_wr; r0 = n_err;
    start_frame();
    body(10, 7, 1, 0);
    #1 reset = 1;
    armed = 0; in_frame = 0;
    tick(3);
    reset = 0;
    release_cs();
    chk("midreset_writes", n_wr - w0, 10);
    chk("midreset_err", n_err - r0, 0);
    chk("midreset_wr_bank", wr_bank, 0);
    chk("midreset_disp_bank", disp_bank, 1);

    d0 = n_done; r0 = n_err;
    start_frame();
    body(FW - 1, 15, 0, 0);
    spi_sclk = 0; spi_mosi = 1;
    tick(2);
    spi_sclk = 1; spi_cs_n = 1;
    rise_model(1);
    cs_rise_model();
    tick(2);
    spi_sclk = 0;
    tick(6);
    chk("simul_done", n_done - d0, 1);
    chk("simul_err", n_err - r0, 0);
    chk("simul_wr_bank", wr_bank, 1);

    w0 = n_wr; r0 = n_err;
    frame(1, 3, 0, 0);
    chk("after_simul_writes", n_wr - w0, 1);
    chk("after_simul_addr", addr_log[w0], 0);
    chk("after_simul_err", n_err - r0, 1);

    for (int k = 0; k < 6; k++) frame($urandom_range(20, 0), $urandom_range(15, 0), 1, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
